// File: rtl/ioctl_sdram_loader.sv
// ioctl_sdram_loader: buffers data_io byte writes and replays them
// as paced single-byte SDRAM writes at a per-image base address.
module ioctl_sdram_loader #(
  parameter int ADDR_W = 23,
  parameter int FIFO_LG2 = 2,
  parameter int WR_GAP = 3,
  parameter logic [ADDR_W-1:0] ROM_BASE = '0,
  parameter logic [ADDR_W-1:0] ALT_BASE = ADDR_W'(23'h040000)
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic [7:0]        ioctl_index,
  input  logic              ram_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              port_own,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] byte_count,
  output logic              overflow
);

  localparam int DEPTH = 1 << FIFO_LG2;
  localparam int EW = ADDR_W + 8;
  localparam int PW = FIFO_LG2 + 1;
  localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e state_q, state_d;
  logic              dl_q;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pbase_q, pbase_d;
  logic [PW-1:0]     wp_q, rp_q;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [GW-1:0]     gap_q, gap_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              rise;
  logic              start;
  logic              empty;
  logic              full;
  logic              issue;
  logic              push;
  logic              drop;
  logic [ADDR_W-1:0] idx_base;
  logic [ADDR_W-1:0] push_base;
  logic [EW-1:0]     head;
  logic              unused_idx;

  assign unused_idx = ^ioctl_index[7:6];

  assign rise = ioctl_download & ~dl_q;
  assign idx_base = (ioctl_index[5:0] == 6'd0) ? ROM_BASE : ALT_BASE;

  assign empty = (wp_q == rp_q);
  assign full = (wp_q[FIFO_LG2] != rp_q[FIFO_LG2]) &&
                (wp_q[FIFO_LG2-1:0] == rp_q[FIFO_LG2-1:0]);

  assign issue = ~empty & ram_ready & (gap_q == '0);
  // A pop in the same cycle frees the slot a push on a full FIFO needs.
  assign push = ioctl_wr & ioctl_download & (~full | issue);
  assign drop = ioctl_wr & ioctl_download & full & ~issue;

  // New writes during a pending re-download use the new image's base.
  assign push_base = rise   ? idx_base :
                     pend_q ? pbase_q  : base_q;

  assign head = mem_q[rp_q[FIFO_LG2-1:0]];

  assign port_own = (state_q != S_IDLE) | ioctl_download;
  assign busy = port_own & (state_q != S_FIN);
  assign done = (state_q == S_FIN);
  assign ram_we = we_q;
  assign ram_addr = addr_q;
  assign ram_din = din_q;
  assign byte_count = cnt_q;
  assign overflow = ovf_q;

  // Download sequencing, base selection and counters.
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    pend_d = pend_q;
    pbase_d = pbase_q;
    start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_LOAD;
          base_d = idx_base;
          start = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (rise) begin
          pend_d = 1'b1;
          pbase_d = idx_base;
        end
        if (empty && gap_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        if (pend_q || rise) begin
          state_d = S_LOAD;
          base_d = rise ? idx_base : pbase_q;
          pend_d = 1'b0;
          start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = start ? '0 : cnt_q;
    if (issue && !(&cnt_d)) cnt_d = cnt_d + ADDR_W'(1);

    ovf_d = start ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;

    gap_d = gap_q;
    if (issue) gap_d = GW'(WR_GAP - 1);
    else if (gap_q != '0) gap_d = gap_q - GW'(1);
  end

  // Control state, pointers and registered SDRAM command.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dl_q <= 1'b0;
      base_q <= ROM_BASE;
      pend_q <= 1'b0;
      pbase_q <= ROM_BASE;
      wp_q <= '0;
      rp_q <= '0;
      gap_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q <= ioctl_download;
      base_q <= base_d;
      pend_q <= pend_d;
      pbase_q <= pbase_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      we_q <= issue;
      if (push) wp_q <= wp_q + PW'(1);
      if (issue) begin
        rp_q <= rp_q + PW'(1);
        addr_q <= head[EW-1:8];
        din_q <= head[7:0];
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wp_q[FIFO_LG2-1:0]] <= {push_base + ioctl_addr, ioctl_data};
    end
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench for ioctl_sdram_loader: a default instance and one
// with ALT_BASE at the top of memory to exercise address wrap.
module tb_ioctl_sdram_loader;

  localparam int AW = 23;
  localparam int GAP = 3;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] ROM_B = 23'h000000;
  localparam logic [AW-1:0] ALT_A = 23'h040000;
  localparam logic [AW-1:0] ALT_B = 23'h7FFFFF;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ioctl_download = 1'b0;
  logic ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0] ioctl_data = 8'h00;
  logic [7:0] ioctl_index = 8'h00;
  logic ram_ready = 1'b0;

  logic [AW-1:0] a_addr, b_addr, a_cnt, b_cnt;
  logic [7:0] a_din, b_din;
  logic a_we, b_we, a_own, b_own, a_busy, b_busy;
  logic a_done, b_done, a_ovf, b_ovf;

  ioctl_sdram_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .ram_ready(ram_ready),
    .ram_addr(a_addr), .ram_din(a_din), .ram_we(a_we),
    .port_own(a_own), .busy(a_busy), .done(a_done),
    .byte_count(a_cnt), .overflow(a_ovf)
  );

  ioctl_sdram_loader #(.ALT_BASE(ALT_B)) dut_alt (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .ram_ready(ram_ready),
    .ram_addr(b_addr), .ram_din(b_din), .ram_we(b_we),
    .port_own(b_own), .busy(b_busy), .done(b_done),
    .byte_count(b_cnt), .overflow(b_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;
  int we_log[$];
  int checks = 0;
  int passed = 0;
  int occ = 0;
  int cyc = 0;
  int wr_seen = 0;
  int last_we = -100;
  int done_cnt = 0;
  int done_cyc = 0;
  bit rnd_rdy = 0;
  logic [7:0] cur_idx = 8'h00;

  function automatic logic [AW-1:0] base_of(input logic [7:0] idx,
                                            input logic [AW-1:0] alt);
    return (idx[5:0] == 6'd0) ? ROM_B : alt;
  endfunction

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk_sys) cyc++;

  // Monitor: every write strobe pops the scoreboard.
  always @(negedge clk_sys) begin
    if (a_we || b_we) check("we_pair", b_we, a_we);
    if (a_we) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr %0h data %0h, none queued",
                 a_addr, a_din);
      end else begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("ram_addr", a_addr, ea.a);
        check("ram_din", a_din, ea.d);
        check("alt_ram_addr", b_addr, eb.a);
        check("alt_ram_din", b_din, eb.d);
        if (occ > 0) occ--;
      end
      checks++;
      if (cyc - last_we >= GAP) passed++;
      else $display("FAIL write_gap: got %0d cycles required >= %0d",
                    cyc - last_we, GAP);
      last_we = cyc;
      we_log.push_back(cyc);
      wr_seen++;
    end
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (rnd_rdy) ram_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    cur_idx = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [7:0] d);
    logic [AW-1:0] xa, xb;
    xa = base_of(cur_idx, ALT_A) + a;
    xb = base_of(cur_idx, ALT_B) + a;
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr = 1'b1;
    if (occ < DEPTH) begin
      qa.push_back(wr_t'{a: xa, d: d});
      qb.push_back(wr_t'{a: xb, d: d});
      occ++;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int s;
    bit ok;
    s = done_cnt;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done_cnt > s) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok) passed++;
    else $display("FAIL done_timeout: no done within %0d cycles", lim);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k, w0, n;
    bit busy_ok, got;
    logic [AW-1:0] ra;

    // Reset state
    repeat (3) tick();
    check("rst_we", a_we, 0);
    check("rst_own", a_own, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_addr", a_addr, 0);
    check("rst_din", a_din, 0);
    reset_n = 1'b1;
    ram_ready = 1'b1;
    repeat (2) tick();

    // Test 1: four slow bytes at index 0
    s0 = done_cnt;
    start_dl(8'h00);
    for (int i = 0; i < 4; i++) begin
      put(AW'(i), 8'hA0 + 8'(i));
      repeat (7) tick();
    end
    end_dl();
    wait_done(50);
    repeat (5) tick();
    check("t1_done_once", done_cnt - s0, 1);
    check("t1_byte_count", a_cnt, 4);
    check("t1_ovf", a_ovf, 0);
    check("t1_drained", qa.size(), 0);
    check("t1_own_idle", a_own, 0);

    // Test 2: alt index, latency of exactly two cycles
    start_dl(8'h01);
    k = cyc;
    put(AW'(23'h10), 8'h5A);
    repeat (4) tick();
    check("t2_latency", last_we - k, 2);
    check("t2_addr", a_addr, 23'h040010);
    check("t2_alt_addr", b_addr, 23'h00000F);
    end_dl();
    wait_done(50);

    // Test 6: alt base at top of memory wraps
    start_dl(8'h02);
    put(AW'(2), 8'h66);
    repeat (4) tick();
    end_dl();
    wait_done(50);
    check("t6_wrap_addr", b_addr, 23'h000001);
    check("t6_addr", a_addr, 23'h040002);
    check("t6_hold_din", b_din, 8'h66);

    // Test 3: stalled SDRAM, six writes, four kept
    ram_ready = 1'b0;
    start_dl(8'h00);
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) put(AW'(23'h100 + i), 8'(8'h30 + i));
    tick();
    check("t3_ovf", a_ovf, 1);
    check("t3_alt_ovf", b_ovf, 1);
    check("t3_stalled", wr_seen - w0, 0);
    ram_ready = 1'b1;
    repeat (20) tick();
    end_dl();
    wait_done(50);
    check("t3_writes", wr_seen - w0, 4);
    check("t3_byte_count", a_cnt, 4);
    if (we_log.size() >= 4)
      for (int i = we_log.size() - 3; i < we_log.size(); i++)
        check("t3_spacing", we_log[i] - we_log[i-1], GAP);
    check("t3_ovf_sticky", a_ovf, 1);

    // Test 4: burst then immediate download fall
    start_dl(8'h00);
    check("t4_ovf_cleared", a_ovf, 0);
    for (int i = 0; i < 4; i++) put(AW'($urandom), 8'($urandom));
    end_dl();
    busy_ok = 1;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      if (a_done) begin
        got = 1;
        break;
      end
      if (!a_busy) busy_ok = 0;
      tick();
    end
    check("t4_done_seen", got, 1);
    check("t4_busy_drain", busy_ok, 1);
    tick();
    check("t4_done_timing", done_cyc - last_we, GAP);
    check("t4_byte_count", a_cnt, 4);

    // Test 5: reset mid-drain with two entries queued
    start_dl(8'h01);
    w0 = wr_seen;
    for (int i = 0; i < 3; i++) put(AW'(23'h200 + i), 8'(8'hC0 + i));
    end_dl();
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_seen > w0) begin
        got = 1;
        break;
      end
      tick();
    end
    check("t5_first_write", got, 1);
    check("t5_cnt_before", a_cnt, 1);
    reset_n = 1'b0;
    qa.delete();
    qb.delete();
    occ = 0;
    #1;
    check("t5_we", a_we, 0);
    check("t5_own", a_own, 0);
    check("t5_cnt", a_cnt, 0);
    check("t5_busy", a_busy, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    w0 = wr_seen;
    repeat (20) tick();
    check("t5_no_writes", wr_seen - w0, 0);

    // Randomized downloads with stalls and index changes
    rnd_rdy = 1;
    for (int t = 0; t < 20; t++) begin
      start_dl(8'($urandom));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        ra = AW'($urandom);
        put(ra, 8'($urandom));
        repeat ($urandom_range(0, 5)) begin
          ioctl_index = 8'($urandom);
          tick();
        end
      end
      end_dl();
      wait_done(200);
      check("rnd_byte_count", a_cnt, n);
      check("rnd_ovf", a_ovf, 0);
      ioctl_addr = AW'($urandom);
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      repeat (3) tick();
      check("rnd_idle_own", a_own, 0);
    end
    rnd_rdy = 0;
    ram_ready = 1'b1;
    repeat (10) tick();
    check("final_drained", qa.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
